// File: rtl/axi_loopback_selftest_chip.sv
// AXI4 loopback self-test chip: traffic-generator master, in-line monitor and
// scoreboard, and a single-beat AXI4 slave memory, all clocked by aclk.
// The internal bus is single-beat only (LEN=0, SIZE=4 bytes, INCR, ID=0,
// WSTRB all ones, RLAST always 1), so those fields are implied, not wired.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | just out of reset; leaves on the first clock (auto-start)
// ST_WR    | AWVALID/WVALID raised, each drops on its own handshake
// ST_WR_RSP| BREADY high, waiting for the write response
// ST_RD    | ARVALID raised for the current read
// ST_RD_DAT| RREADY high, waiting for the read beat
// ST_DONE  | run complete, status held until start
module axi_loopback_selftest_chip #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                MEM_DEPTH    = 16,
    parameter int                NUM_TXN      = 16,
    parameter logic [DATA_W-1:0] PATTERN_BASE = 32'hC0DE_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        inject_err,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR     = 3'd1;
    localparam logic [2:0] ST_WR_RSP = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_RD_DAT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int                IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] IDX_MASK    = ADDR_W'((MEM_DEPTH - 1) << 2);
    localparam logic [15:0]       LAST_TXN    = 16'(NUM_TXN - 1);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    logic [2:0]        state;
    logic [15:0]       txn_idx;
    logic              aw_pend, w_pend, ar_pend;

    logic [ADDR_W-1:0] awaddr, araddr;
    logic [DATA_W-1:0] wdata, rdata, exp_rdata;
    logic              awvalid, awready, wvalid, wready;
    logic              bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]        bresp, rresp;
    logic              aw_fire, w_fire, b_fire, ar_fire, r_fire;

    assign awaddr    = ADDR_W'({txn_idx, 2'b00});
    assign araddr    = ADDR_W'({txn_idx, 2'b00});
    assign exp_rdata = PATTERN_BASE + DATA_W'(txn_idx);
    assign wdata     = exp_rdata ^ DATA_W'(inject_err);
    assign awvalid   = aw_pend;
    assign wvalid    = w_pend;
    assign arvalid   = ar_pend;
    assign bready    = (state == ST_WR_RSP);
    assign rready    = (state == ST_RD_DAT);

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign b_fire  = bvalid & bready;
    assign ar_fire = arvalid & arready;
    assign r_fire  = rvalid & rready;

    // Master sequencer: NUM_TXN writes, then NUM_TXN reads of the same words.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            txn_idx <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            ar_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state   <= ST_WR;
                    txn_idx <= '0;
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                end
                ST_WR: begin
                    if (aw_fire) aw_pend <= 1'b0;
                    if (w_fire)  w_pend  <= 1'b0;
                    if ((!aw_pend || aw_fire) && (!w_pend || w_fire)) state <= ST_WR_RSP;
                end
                ST_WR_RSP: begin
                    if (b_fire) begin
                        if (txn_idx == LAST_TXN) begin
                            txn_idx <= '0;
                            ar_pend <= 1'b1;
                            state   <= ST_RD;
                        end else begin
                            txn_idx <= txn_idx + 16'd1;
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (ar_fire) begin
                        ar_pend <= 1'b0;
                        state   <= ST_RD_DAT;
                    end
                end
                ST_RD_DAT: begin
                    if (r_fire) begin
                        if (txn_idx == LAST_TXN) begin
                            state <= ST_DONE;
                        end else begin
                            txn_idx <= txn_idx + 16'd1;
                            ar_pend <= 1'b1;
                            state   <= ST_RD;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state   <= ST_WR;
                        txn_idx <= '0;
                        aw_pend <= 1'b1;
                        w_pend  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic       err_hit;
    logic [7:0] err_next;
    logic       run_last;

    assign err_hit  = (b_fire && bresp != RESP_OKAY) ||
                      (r_fire && (rresp != RESP_OKAY || rdata != exp_rdata));
    assign err_next = (err_hit && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    assign run_last = r_fire && (state == ST_RD_DAT) && (txn_idx == LAST_TXN);

    // Monitor counters, scoreboard error count and the done/pass status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else if (state == ST_DONE && start) begin
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            if (b_fire) wr_cnt <= wr_cnt + 16'd1;
            if (r_fire) rd_cnt <= rd_cnt + 16'd1;
            err_cnt <= err_next;
            if (run_last) begin
                done <= 1'b1;
                pass <= (err_next == 8'd0);
            end
        end
    end

    // Slave write path: AW and W are captured independently, commit when both held.
    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q, wr_addr;
    logic [DATA_W-1:0] w_data_q, wr_data;
    logic              wr_commit, wr_err;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    assign awready   = !bvalid && !aw_held;
    assign wready    = !bvalid && !w_held;
    assign wr_addr   = aw_fire ? awaddr : aw_addr_q;
    assign wr_data   = w_fire ? wdata : w_data_q;
    assign wr_commit = (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_err    = |(wr_addr & ~IDX_MASK);
    assign wr_idx    = wr_addr[IDX_W+1:2];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            if (b_fire) bvalid <= 1'b0;
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_fire) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= wdata;
                end
            end
        end
    end

    // Memory array is deliberately left out of reset.
    always_ff @(posedge aclk) begin
        if (wr_commit && !wr_err) mem[wr_idx] <= wr_data;
    end

    // Slave read path: one beat, returned the cycle after the AR handshake.
    logic             rd_err;
    logic [IDX_W-1:0] rd_idx;

    assign arready = !rvalid;
    assign rd_err  = |(araddr & ~IDX_MASK);
    assign rd_idx  = araddr[IDX_W+1:2];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_fire) begin
            rvalid <= 1'b1;
            rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rdata  <= rd_err ? '0 : mem[rd_idx];
        end else if (r_fire) begin
            rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_loopback_selftest_chip.sv
// Directed/randomized bench for the AXI loopback self-test chip.
module tb_axi_loopback_selftest_chip;
    localparam int          N  = 16;
    localparam logic [31:0] PB = 32'hC0DE_0000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        inject_err = 1'b0;
    logic        done, pass;
    logic [7:0]  err_cnt;
    logic [15:0] wr_cnt, rd_cnt;

    logic        start4 = 1'b0;
    logic        inject4 = 1'b0;
    logic        done4, pass4;
    logic [7:0]  err_cnt4;
    logic [15:0] wr_cnt4, rd_cnt4;

    int checks = 0;
    int failures = 0;
    bit inj [1:2*N];

    axi_loopback_selftest_chip dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .inject_err(inject_err),
        .done(done), .pass(pass), .err_cnt(err_cnt), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    axi_loopback_selftest_chip #(.NUM_TXN(4)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .start(start4), .inject_err(inject4),
        .done(done4), .pass(pass4), .err_cnt(err_cnt4), .wr_cnt(wr_cnt4), .rd_cnt(rd_cnt4)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            @(negedge aclk);
            cyc++;
        end
    endtask

    // Start a run with inject_err following inj[] cycle by cycle. With nominal
    // 2-cycle writes, write i is sampled at the (1+2i)-th clock after the start
    // clock, so the expected error count is the number of set inj[1+2i].
    task automatic inj_run(output int exp_err);
        exp_err = 0;
        for (int i = 0; i < N; i++) exp_err += int'(inj[1 + 2*i]);
        @(negedge aclk);
        start = 1'b1;
        for (int k = 1; k <= 2*N; k++) begin
            @(negedge aclk);
            start = 1'b0;
            inject_err = inj[k];
        end
        @(negedge aclk);
        inject_err = 1'b0;
    endtask

    initial begin
        int cyc;
        int exp_err;

        repeat (3) @(negedge aclk);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_wr", wr_cnt, 0);
        check("rst_rd", rd_cnt, 0);
        repeat (5) @(negedge aclk);
        check("hold_done", done, 0);
        check("hold_wr", wr_cnt, 0);

        aresetn = 1'b1;
        wait_done(4*N + 4, cyc);
        check("run1_done", done, 1);
        check("run1_latency_ok", cyc <= 4*N + 4, 1);
        check("run1_pass", pass, 1);
        check("run1_err", err_cnt, 0);
        check("run1_wr", wr_cnt, N);
        check("run1_rd", rd_cnt, N);
        repeat (3) @(negedge aclk);
        check("done_hold", done, 1);
        check("done_hold_wr", wr_cnt, N);

        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        check("restart_done", done, 0);
        check("restart_pass", pass, 0);
        check("restart_wr", wr_cnt, 0);
        check("restart_rd", rd_cnt, 0);
        wait_done(4*N + 4, cyc);
        check("run2_done", done, 1);
        check("run2_pass", pass, 1);
        check("run2_wr", wr_cnt, N);
        check("run2_rd", rd_cnt, N);

        for (int k = 1; k <= 2*N; k++) inj[k] = 1'b1;
        inj_run(exp_err);
        wait_done(4*N + 4, cyc);
        check("inj_all_done", done, 1);
        check("inj_all_err", err_cnt, exp_err);
        check("inj_all_err16", err_cnt, 16);
        check("inj_all_pass", pass, 0);
        check("inj_all_wr", wr_cnt, N);
        check("inj_all_rd", rd_cnt, N);

        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= 2*N; k++) inj[k] = 1'($urandom_range(0, 1));
            inj_run(exp_err);
            wait_done(4*N + 4, cyc);
            check("inj_rnd_done", done, 1);
            check("inj_rnd_err", err_cnt, exp_err);
            check("inj_rnd_pass", pass, (exp_err == 0) ? 1 : 0);
            check("inj_rnd_rd", rd_cnt, N);
        end

        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat ($urandom_range(4, 12)) @(negedge aclk);
        check("midrst_pre_wr_nonzero", wr_cnt != 0, 1);
        #2 aresetn = 1'b0;
        #1;
        check("midrst_async_wr", wr_cnt, 0);
        check("midrst_async_done", done, 0);
        check("midrst_async_pass", pass, 0);
        repeat ($urandom_range(1, 5)) @(negedge aclk);
        check("midrst_hold_wr", wr_cnt, 0);
        aresetn = 1'b1;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_done(4*N + 4, cyc);
        check("midrst_done", done, 1);
        check("midrst_pass", pass, 1);
        check("midrst_wr", wr_cnt, N);
        check("midrst_rd", rd_cnt, N);

        check("n4_done", done4, 1);
        check("n4_pass", pass4, 1);
        check("n4_wr", wr_cnt4, 4);
        check("n4_rd", rd_cnt4, 4);
        check("n4_mem3", dut4.mem[3], PB + 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
